// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: data width, default bubble
// instruction, fetch FSM state encoding and the {pc,inst} packet type.
package if_fetch_unit_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 -- what the IF/ID register sees while no real instruction is presented
    localparam logic [XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_pkt_t;

    // Fetches are always word aligned, so the low two address bits are dropped
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus. The fetch unit is the master,
// the instruction memory is the slave.
interface if_fetch_unit_if import if_fetch_unit_pkg::*; ;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_unit_skid_buf.sv
// One-entry {pc,inst} holding slot used when a fetched instruction returns
// while the output register is still occupied by a stalled instruction.
module fetch_skid_buf import if_fetch_unit_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  fetch_pkt_t push_pkt,
    output logic       full,
    output fetch_pkt_t head_pkt
);

    // A push on the same edge as a pop replaces the entry that is leaving, so the slot stays full
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            full     <= 1'b0;
            head_pkt <= '0;
        end else if (push) begin
            full     <= 1'b1;
            head_pkt <= push_pkt;
        end else if (pop) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// request outstanding and presents fetched instructions to the IF/ID register,
// surviving variable memory latency, downstream stalls and redirects.
module if_fetch_unit import if_fetch_unit_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic                   clk_IF,
    input  logic                   rst_n_IF,
    input  logic                   stall_IF,
    input  logic                   redirect_IF,
    input  logic [XLEN-1:0]        redirect_pc_IF,
    if_fetch_unit_if.master        imem,
    output logic [XLEN-1:0]        PC_out_IF,
    output logic [XLEN-1:0]        inst_out_IF,
    output logic                   valid_out_IF
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    logic            out_valid_q;
    logic [XLEN-1:0] out_pc_q;
    logic [XLEN-1:0] out_inst_q;

    logic            handshake;
    logic            resp;
    logic            consume;
    logic            deliver;
    logic            skid_full;
    logic            skid_push;
    logic            skid_pop;
    fetch_pkt_t      skid_head;
    fetch_pkt_t      resp_pkt;

    // Requests stop while the skid slot is full so nothing returns with nowhere to go
    assign imem.imem_req  = (state_q == S_REQ) && !skid_full;
    assign imem.imem_addr = pc_q;

    assign handshake = imem.imem_req && imem.imem_gnt;
    assign resp      = imem.imem_rvalid && ((state_q == S_WAIT) || (state_q == S_DRAIN));
    assign consume   = out_valid_q && !stall_IF;
    assign deliver   = resp && (state_q == S_WAIT) && !redirect_IF;
    assign resp_pkt  = {fetch_pc_q, imem.imem_rdata};

    // New data goes to the skid slot only when the output register is busy this edge
    assign skid_push = deliver && (consume ? skid_full : out_valid_q);
    assign skid_pop  = consume && skid_full;

    fetch_skid_buf u_skid (
        .clk      (clk_IF),
        .rst_n    (rst_n_IF),
        .flush    (redirect_IF),
        .push     (skid_push),
        .pop      (skid_pop),
        .push_pkt (resp_pkt),
        .full     (skid_full),
        .head_pkt (skid_head)
    );

    // Next-state and PC update; a redirect overrides the normal transition and kills any live request
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            S_RST:   state_d = S_REQ;
            S_REQ: begin
                if (handshake) begin
                    pc_d       = pc_q + 32'd4;
                    fetch_pc_d = pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT:  if (resp) state_d = S_REQ;
            S_DRAIN: if (resp) state_d = S_REQ;
            default: state_d = S_RST;
        endcase
        if (redirect_IF) begin
            pc_d = align_word(redirect_pc_IF);
            if (handshake) begin
                state_d = S_DRAIN;
            end else if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !resp) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    // FSM state, fetch PC and the PC of the outstanding request
    always_ff @(posedge clk_IF) begin
        if (!rst_n_IF) begin
            state_q    <= S_RST;
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Output register: refilled from the skid slot first to keep program order, then from memory
    always_ff @(posedge clk_IF) begin
        if (!rst_n_IF) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= NOP_INST;
        end else if (redirect_IF) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= NOP_INST;
        end else if (consume && skid_full) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= skid_head.pc;
            out_inst_q  <= skid_head.inst;
        end else if (deliver && (consume || !out_valid_q)) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= resp_pkt.pc;
            out_inst_q  <= resp_pkt.inst;
        end else if (consume) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= NOP_INST;
        end
    end

    assign PC_out_IF    = out_pc_q;
    assign inst_out_IF  = out_inst_q;
    assign valid_out_IF = out_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: a behavioural memory with random latency and grant,
// and a reference model that tracks presented instructions as an ordered queue.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk_IF = 1'b0;
    logic        rst_n_IF;
    logic        stall_IF;
    logic        redirect_IF;
    logic [31:0] redirect_pc_IF;
    logic [31:0] PC_out_IF;
    logic [31:0] inst_out_IF;
    logic        valid_out_IF;

    if_fetch_unit_if imem_bus ();

    if_fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk_IF         (clk_IF),
        .rst_n_IF       (rst_n_IF),
        .stall_IF       (stall_IF),
        .redirect_IF    (redirect_IF),
        .redirect_pc_IF (redirect_pc_IF),
        .imem           (imem_bus),
        .PC_out_IF      (PC_out_IF),
        .inst_out_IF    (inst_out_IF),
        .valid_out_IF   (valid_out_IF)
    );

    always #5 clk_IF = ~clk_IF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    // Instructions waiting to be consumed, oldest first (output register + skid slot)
    entry_t      exp_q[$];
    bit          model_live;
    bit          in_rst;
    bit          outst;
    bit          killed;
    int          cnt;
    logic [31:0] out_addr;
    logic [31:0] next_fetch;

    int lat_min, lat_max, gnt_pct, stall_pct, redir_pct;
    bit stray_en;

    int n_cmp;
    int n_fail;
    int n_consumed;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit exp_req;
        exp_req = !in_rst && !outst && (exp_q.size() < 2);
        check("valid_out", {31'b0, valid_out_IF}, {31'b0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
            check("pc_out", PC_out_IF, exp_q[0].pc);
            check("inst_out", inst_out_IF, exp_q[0].inst);
        end else begin
            check("inst_nop", inst_out_IF, NOP);
        end
        check("imem_req", {31'b0, imem_bus.imem_req}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", imem_bus.imem_addr, next_fetch);
    endtask

    task automatic applyStimulus(input bit rst_n_in, input bit redir_in,
                                 input logic [31:0] tgt_in, input bit stall_in);
        bit          exp_req, hs, resp, consume;
        logic [31:0] old_fetch;
        entry_t      e;
        rst_n_IF       = rst_n_in;
        stall_IF       = stall_in || ($urandom_range(99) < stall_pct);
        redirect_IF    = rst_n_in && (redir_in || ($urandom_range(99) < redir_pct));
        redirect_pc_IF = redir_in ? tgt_in : 32'($urandom_range(0, 4095));
        imem_bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = $urandom;
        if (outst) begin
            cnt--;
            if (cnt == 0) begin
                imem_bus.imem_rvalid = 1'b1;
                imem_bus.imem_rdata  = mem_word(out_addr);
            end
        end else if (stray_en && ($urandom_range(1) == 1)) begin
            imem_bus.imem_rvalid = 1'b1;
        end
        exp_req = !in_rst && !outst && (exp_q.size() < 2);
        hs      = exp_req && imem_bus.imem_gnt;
        resp    = outst && imem_bus.imem_rvalid;
        consume = (exp_q.size() > 0) && !stall_IF;
        if (!rst_n_in) begin
            exp_q.delete();
            outst      = 0;
            killed     = 0;
            in_rst     = 1;
            next_fetch = RESET_PC;
            model_live = 1;
        end else begin
            in_rst = 0;
            if (redirect_IF) begin
                exp_q.delete();
                old_fetch  = next_fetch;
                next_fetch = redirect_pc_IF & ~32'h3;
                if (resp) outst = 0;
                else if (outst) killed = 1;
                if (hs) begin
                    outst    = 1;
                    killed   = 1;
                    cnt      = $urandom_range(lat_max, lat_min);
                    out_addr = old_fetch;
                end
            end else begin
                if (consume) begin
                    void'(exp_q.pop_front());
                    n_consumed++;
                end
                if (resp) begin
                    outst = 0;
                    if (!killed) begin
                        e.pc   = out_addr;
                        e.inst = mem_word(out_addr);
                        exp_q.push_back(e);
                    end
                end
                if (hs) begin
                    outst      = 1;
                    killed     = 0;
                    cnt        = $urandom_range(lat_max, lat_min);
                    out_addr   = next_fetch;
                    next_fetch = next_fetch + 32'd4;
                end
            end
        end
    endtask

    task automatic stepCycle(input bit rst_n_in, input bit redir_in,
                             input logic [31:0] tgt_in, input bit stall_in);
        @(negedge clk_IF);
        if (model_live) checkOutput();
        applyStimulus(rst_n_in, redir_in, tgt_in, stall_in);
    endtask

    task automatic idle();
        stepCycle(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic doReset();
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0);
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          first_valid, prev_valid, found, seen_req, seen_valid, consumed_before;
        logic [31:0] seen_pcs[3];
        int          n_seen;

        n_cmp = 0; n_fail = 0; n_consumed = 0;
        model_live = 0; in_rst = 1; outst = 0; killed = 0; cnt = 0;
        out_addr = '0; next_fetch = RESET_PC;
        lat_min = 1; lat_max = 1; gnt_pct = 100; stall_pct = 0; redir_pct = 0; stray_en = 0;
        rst_n_IF = 1'b0; stall_IF = 1'b0; redirect_IF = 1'b0; redirect_pc_IF = '0;
        imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;

        // Reset release, latency 1: reset state, then first valid three cycles after release
        doReset();
        first_valid = -1;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (i == 0) begin
                check("rst_pc_out", PC_out_IF, 32'h0);
                check("rst_inst", inst_out_IF, NOP);
                check("rst_valid", {31'b0, valid_out_IF}, 32'h0);
                check("rst_req", {31'b0, imem_bus.imem_req}, 32'h0);
            end
            if (valid_out_IF === 1'b1) begin
                first_valid = i;
                break;
            end
        end
        check("first_valid_cycle", first_valid, 3);
        repeat (12) idle();

        // Latency 3: one instruction every four cycles
        lat_min = 3; lat_max = 3;
        doReset();
        prev_valid = -1;
        for (int i = 0; i < 30; i++) begin
            idle();
            if (valid_out_IF === 1'b1) begin
                if (prev_valid >= 0) check("lat3_gap", i - prev_valid, 4);
                prev_valid = i;
            end
        end

        // Stall at PC 0x10: outputs freeze, fetch stops once the skid slot fills, nothing lost
        lat_min = 1; lat_max = 1;
        doReset();
        found = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (exp_q.size() > 0 && exp_q[0].pc == 32'h10) begin
                found = 1;
                break;
            end
        end
        check("reach_pc10", found, 1);
        repeat (6) stepCycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("stall_pc_frozen", PC_out_IF, 32'h10);
        check("stall_req_off", {31'b0, imem_bus.imem_req}, 32'h0);
        n_seen = 0;
        prev_valid = 0;
        for (int i = 0; i < 15 && n_seen < 3; i++) begin
            idle();
            if (valid_out_IF === 1'b1) begin
                seen_pcs[n_seen] = PC_out_IF;
                n_seen++;
            end
        end
        check("stall_seq_count", n_seen, 3);
        check("stall_seq0", seen_pcs[0], 32'h10);
        check("stall_seq1", seen_pcs[1], 32'h14);
        check("stall_seq2", seen_pcs[2], 32'h18);

        // Redirect to 0x103 while waiting for PC 0x20
        lat_min = 3; lat_max = 3;
        doReset();
        found = 0;
        for (int i = 0; i < 80; i++) begin
            idle();
            if (outst && !killed && out_addr == 32'h20 && cnt >= 2) begin
                found = 1;
                break;
            end
        end
        check("reach_wait_pc20", found, 1);
        stepCycle(1'b1, 1'b1, 32'h0000_0103, 1'b0);
        seen_req = 0; seen_valid = 0;
        for (int i = 0; i < 30 && !seen_valid; i++) begin
            idle();
            if (!seen_req && imem_bus.imem_req === 1'b1) begin
                check("redir_addr", imem_bus.imem_addr, 32'h100);
                seen_req = 1;
            end
            if (valid_out_IF === 1'b1) begin
                check("redir_first_pc", PC_out_IF, 32'h100);
                seen_valid = 1;
            end
        end
        check("redir_seen_valid", seen_valid, 1);

        // Redirect in the same cycle as rvalid, then redirect while stalled
        lat_min = 2; lat_max = 2;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (outst && !killed && cnt == 1) begin
                found = 1;
                break;
            end
        end
        check("reach_rvalid_cycle", found, 1);
        stepCycle(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        idle();
        check("redir_rvalid_drop", {31'b0, valid_out_IF}, 32'h0);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (exp_q.size() > 0) begin
                found = 1;
                break;
            end
        end
        check("reach_valid", found, 1);
        stepCycle(1'b1, 1'b1, 32'h0000_0300, 1'b1);
        idle();
        check("redir_stall_drop", {31'b0, valid_out_IF}, 32'h0);
        repeat (10) idle();

        // Reset during a wait, stray rvalid afterwards, restart at RESET_PC
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (outst && cnt >= 2) begin
                found = 1;
                break;
            end
        end
        check("reach_wait_rst", found, 1);
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0);
        gnt_pct = 0; stray_en = 1;
        for (int i = 0; i < 4; i++) begin
            idle();
            check("stray_ignored", {31'b0, valid_out_IF}, 32'h0);
        end
        gnt_pct = 100; stray_en = 0;
        seen_req = 0; seen_valid = 0;
        for (int i = 0; i < 20 && !seen_valid; i++) begin
            idle();
            if (!seen_req && imem_bus.imem_req === 1'b1) begin
                check("restart_addr", imem_bus.imem_addr, RESET_PC);
                seen_req = 1;
            end
            if (valid_out_IF === 1'b1) begin
                check("restart_pc", PC_out_IF, RESET_PC);
                seen_valid = 1;
            end
        end
        check("restart_seen_valid", seen_valid, 1);

        // Random traffic: variable latency and grant, stalls, redirects, stray responses
        lat_min = 1; lat_max = 4; gnt_pct = 70; stall_pct = 30; redir_pct = 4; stray_en = 1;
        consumed_before = n_consumed;
        repeat (800) idle();
        check("random_progress", {31'b0, (n_consumed - consumed_before) > 50}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
